// File: rtl/spi_nor_flash_model.sv
// Byte-wide SPI NOR flash device model: decodes command / 24-bit address / 32-bit data
// frames from the flash controller against a small word array and reports per-frame status.
module spi_nor_flash_model #(
   parameter int          DEPTH  = 16,
   parameter int          AW     = 4,
   parameter logic [31:0] ERASED = 32'hFFFF_FFFF
) (
   input  logic       p_clk,
   input  logic       p_reset,
   input  logic       s_clk,
   input  logic       s_css,
   input  logic [7:0] s_mosi,
   output logic [7:0] s_miso,
   output logic       busy,
   output logic       wr_done,
   output logic       cmd_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;

   state_t      state_q,   state_d;
   logic [1:0]  cnt_q,     cnt_d;
   logic        is_read_q, is_read_d;
   logic [15:0] addr_hi_q, addr_hi_d;
   logic [AW-1:0] idx_q,   idx_d;
   logic [23:0] shift_q,   shift_d;
   logic [7:0]  miso_q,    miso_d;
   logic        busy_q,    busy_d;
   logic        wr_done_q, wr_done_d;
   logic        cmd_err_q, cmd_err_d;
   logic        s_clk_q,   s_css_q;

   logic [31:0] mem_q [DEPTH];

   logic        rise, cs_fall, cs_rise;
   logic [23:0] full_addr;
   logic [31:0] rd_word;
   logic        wr_en;

   assign rise      = s_clk & ~s_clk_q & ~s_css;
   assign cs_fall   = ~s_css & s_css_q;
   assign cs_rise   = s_css & ~s_css_q;
   assign full_addr = {addr_hi_q, s_mosi};
   assign rd_word   = mem_q[idx_q];

   // NOTE: every variable gets a default at the top of always_comb; a path that leaves one
   // unassigned would infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_read_d = is_read_q;
      addr_hi_d = addr_hi_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      miso_d    = miso_q;
      busy_d    = busy_q;
      wr_done_d = 1'b0;
      cmd_err_d = 1'b0;
      wr_en     = 1'b0;

      if (cs_rise) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         miso_d  = 8'h00;
      end else if (cs_fall && state_q != S_IDLE) begin
         // chip select bounced without a clock: start the frame over
         state_d = S_CMD;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cs_fall) begin
                  state_d = S_CMD;
                  busy_d  = 1'b1;
                  cnt_d   = 2'd0;
               end
            end
            S_CMD: begin
               if (rise) begin
                  cnt_d = 2'd0;
                  if (s_mosi == OP_WRITE) begin
                     is_read_d = 1'b0;
                     state_d   = S_ADDR;
                  end else if (s_mosi == OP_READ) begin
                     is_read_d = 1'b1;
                     state_d   = S_ADDR;
                  end else begin
                     state_d   = S_DONE;
                     cmd_err_d = 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (rise) begin
                  cnt_d = cnt_q + 2'd1;
                  case (cnt_q)
                     2'd0:    addr_hi_d[15:8] = s_mosi;
                     2'd1:    addr_hi_d[7:0]  = s_mosi;
                     default: begin
                        cnt_d = 2'd0;
                        idx_d = s_mosi[AW-1:0];
                        if (full_addr >= 24'(DEPTH)) begin
                           state_d   = S_DONE;
                           cmd_err_d = 1'b1;
                           if (is_read_q) miso_d = 8'hFF;
                        end else begin
                           state_d = S_DATA;
                           if (is_read_q) miso_d = mem_q[s_mosi[AW-1:0]][31:24];
                        end
                     end
                  endcase
               end
            end
            S_DATA: begin
               if (rise) begin
                  cnt_d = cnt_q + 2'd1;
                  if (is_read_q) begin
                     case (cnt_q)
                        2'd0:    miso_d  = rd_word[23:16];
                        2'd1:    miso_d  = rd_word[15:8];
                        2'd2:    miso_d  = rd_word[7:0];
                        default: state_d = S_DONE;
                     endcase
                  end else begin
                     shift_d = {shift_q[15:0], s_mosi};
                     if (cnt_q == 2'd3) begin
                        wr_en     = 1'b1;
                        wr_done_d = 1'b1;
                        state_d   = S_DONE;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
   // values from before this edge regardless of statement order.
   always_ff @(posedge p_clk) begin
      s_clk_q <= s_clk;
      s_css_q <= s_css;
      if (p_reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 2'd0;
         is_read_q <= 1'b0;
         addr_hi_q <= 16'h0000;
         idx_q     <= '0;
         shift_q   <= 24'h00_0000;
         miso_q    <= 8'h00;
         busy_q    <= 1'b0;
         wr_done_q <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_read_q <= is_read_d;
         addr_hi_q <= addr_hi_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         miso_q    <= miso_d;
         busy_q    <= busy_d;
         wr_done_q <= wr_done_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   // NOTE: the array is built from resettable flops because reset must return every word to
   // the erased value; a RAM macro could not do that in one cycle.
   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= ERASED;
      end else if (wr_en) begin
         mem_q[idx_q] <= {shift_q, s_mosi};
      end
   end

   assign s_miso  = miso_q;
   assign busy    = busy_q;
   assign wr_done = wr_done_q;
   assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_nor_flash_model.sv
// Directed bench for spi_nor_flash_model: drives controller-style SPI frames and compares
// s_miso bytes and status pulses against hand-computed values.
module tb_spi_nor_flash_model;

   logic       p_clk   = 1'b0;
   logic       p_reset = 1'b1;
   logic       s_clk   = 1'b0;
   logic       s_css   = 1'b1;
   logic [7:0] s_mosi  = 8'h00;
   logic [7:0] s_miso;
   logic       busy, wr_done, cmd_err;

   int errors = 0;
   int checks = 0;
   int wr_pulses = 0, err_pulses = 0, both_seen = 0;
   logic xfer_err, xfer_done, xfer_err_next;

   spi_nor_flash_model #(.DEPTH(16), .AW(4), .ERASED(32'hFFFF_FFFF)) dut (
      .p_clk   (p_clk),
      .p_reset (p_reset),
      .s_clk   (s_clk),
      .s_css   (s_css),
      .s_mosi  (s_mosi),
      .s_miso  (s_miso),
      .busy    (busy),
      .wr_done (wr_done),
      .cmd_err (cmd_err)
   );

   always #5 p_clk = ~p_clk;

   always @(negedge p_clk) begin
      if (wr_done) wr_pulses++;
      if (cmd_err) err_pulses++;
      if (wr_done && cmd_err) both_seen++;
   end

   // One SPI byte: s_clk high for 2 p_clk, low for 2 p_clk; samples one p_clk after the rise.
   task automatic xfer(input logic [7:0] b, output logic [7:0] miso_s);
      @(negedge p_clk);
      s_mosi = b;
      s_clk  = 1'b1;
      @(negedge p_clk);
      miso_s    = s_miso;
      xfer_err  = cmd_err;
      xfer_done = wr_done;
      @(negedge p_clk);
      xfer_err_next = cmd_err;
      s_clk = 1'b0;
      @(negedge p_clk);
   endtask

   task automatic cs_low();
      @(negedge p_clk);
      s_css = 1'b0;
      @(negedge p_clk);
   endtask

   task automatic cs_high(output logic busy_after, output logic [7:0] miso_after);
      @(negedge p_clk);
      s_css = 1'b1;
      @(negedge p_clk);
      busy_after = busy;
      miso_after = s_miso;
   endtask

   task automatic read_frame(input logic [23:0] a, output logic [31:0] got,
                             output logic [7:0] last, output logic busy_open,
                             output logic busy_closed, output logic [7:0] miso_closed);
      logic [7:0] d, b0, b1, b2, b3;
      cs_low();
      xfer(8'h01, d);
      xfer(a[23:16], d);
      xfer(a[15:8], d);
      xfer(a[7:0], b0);
      xfer(8'h00, b1);
      xfer(8'h00, b2);
      xfer(8'h00, b3);
      xfer(8'h00, last);
      got       = {b0, b1, b2, b3};
      busy_open = busy;
      cs_high(busy_closed, miso_closed);
   endtask

   task automatic write_frame(input logic [23:0] a, input logic [31:0] data, input int nbytes);
      logic [7:0] d;
      logic       bz;
      logic [7:0] m;
      cs_low();
      xfer(8'h02, d);
      xfer(a[23:16], d);
      xfer(a[15:8], d);
      xfer(a[7:0], d);
      for (int i = 0; i < nbytes; i++) xfer(data[31-8*i -: 8], d);
      cs_high(bz, m);
   endtask

   task automatic test_reset();
      p_reset = 1'b1;
      repeat (3) @(negedge p_clk);
      p_reset = 1'b0;
      @(negedge p_clk);
      checks++; if (s_miso !== 8'h00) begin errors++; $display("FAIL reset_miso got=%h exp=00", s_miso); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (wr_done !== 1'b0 || cmd_err !== 1'b0) begin
         errors++; $display("FAIL reset_pulses wr_done=%b cmd_err=%b exp=0,0", wr_done, cmd_err);
      end
   endtask

   task automatic test_read_erased();
      logic [31:0] got;
      logic [7:0]  last, mc;
      logic        bo, bc;
      int          e0;
      e0 = err_pulses;
      read_frame(24'h000000, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL read_erased_bytes got=%h exp=ffffffff", got); end
      checks++; if (last !== 8'hFF) begin errors++; $display("FAIL read_erased_hold got=%h exp=ff", last); end
      checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL read_erased_cmd_err got=%0d exp=0", err_pulses - e0); end
      checks++; if (bo !== 1'b1) begin errors++; $display("FAIL busy_open got=%b exp=1", bo); end
      checks++; if (bc !== 1'b0) begin errors++; $display("FAIL busy_drop got=%b exp=0", bc); end
      checks++; if (mc !== 8'h00) begin errors++; $display("FAIL miso_after_cs got=%h exp=00", mc); end
   endtask

   task automatic test_write_read();
      logic [31:0] got;
      logic [7:0]  last, mc;
      logic        bo, bc;
      int          w0;
      w0 = wr_pulses;
      write_frame(24'h000003, 32'hFF00_FF00, 4);
      checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL wr_done_timing got=%b exp=1", xfer_done); end
      checks++; if (wr_pulses - w0 !== 1) begin errors++; $display("FAIL wr_done_count got=%0d exp=1", wr_pulses - w0); end
      read_frame(24'h000003, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFF00_FF00) begin errors++; $display("FAIL read_back_addr3 got=%h exp=ff00ff00", got); end
      checks++; if (last !== 8'h00) begin errors++; $display("FAIL read_back_hold got=%h exp=00", last); end
      w0 = wr_pulses;
      write_frame(24'h00000F, 32'hA5A5_5A5A, 4);
      read_frame(24'h00000F, got, last, bo, bc, mc);
      checks++; if (got !== 32'hA5A5_5A5A) begin errors++; $display("FAIL read_back_top got=%h exp=a5a55a5a", got); end
      checks++; if (wr_pulses - w0 !== 1) begin errors++; $display("FAIL wr_done_top got=%0d exp=1", wr_pulses - w0); end
   endtask

   task automatic test_bad_opcode();
      logic [31:0] got;
      logic [7:0]  d, last, mc;
      logic        bo, bc;
      int          e0, w0;
      e0 = err_pulses;
      w0 = wr_pulses;
      cs_low();
      xfer(8'h05, d);
      checks++; if (xfer_err !== 1'b1) begin errors++; $display("FAIL bad_op_err got=%b exp=1", xfer_err); end
      checks++; if (xfer_err_next !== 1'b0) begin errors++; $display("FAIL bad_op_err_width got=%b exp=0", xfer_err_next); end
      xfer(8'h00, d); xfer(8'h00, d); xfer(8'h00, d);
      xfer(8'h12, d); xfer(8'h34, d); xfer(8'h56, d); xfer(8'h78, d);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_op_busy got=%b exp=1", busy); end
      cs_high(bc, mc);
      checks++; if (err_pulses - e0 !== 1 || wr_pulses - w0 !== 0) begin
         errors++; $display("FAIL bad_op_pulses cmd_err=%0d wr_done=%0d exp=1,0", err_pulses - e0, wr_pulses - w0);
      end
      read_frame(24'h000000, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bad_op_array got=%h exp=ffffffff", got); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] got;
      logic [7:0]  last, mc;
      logic        bo, bc;
      int          e0, w0;
      e0 = err_pulses;
      w0 = wr_pulses;
      write_frame(24'h000010, 32'h1122_3344, 4);
      checks++; if (err_pulses - e0 !== 1 || wr_pulses - w0 !== 0) begin
         errors++; $display("FAIL oor_write_pulses cmd_err=%0d wr_done=%0d exp=1,0", err_pulses - e0, wr_pulses - w0);
      end
      e0 = err_pulses;
      read_frame(24'h000010, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFFFF_FFFF || last !== 8'hFF) begin
         errors++; $display("FAIL oor_read_miso got=%h/%h exp=ffffffff/ff", got, last);
      end
      checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL oor_read_err got=%0d exp=1", err_pulses - e0); end
      read_frame(24'h000000, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL oor_no_wrap got=%h exp=ffffffff", got); end
      e0 = err_pulses;
      w0 = wr_pulses;
      write_frame(24'h010003, 32'h0BAD_0BAD, 4);
      checks++; if (err_pulses - e0 !== 1 || wr_pulses - w0 !== 0) begin
         errors++; $display("FAIL oor_high_byte cmd_err=%0d wr_done=%0d exp=1,0", err_pulses - e0, wr_pulses - w0);
      end
      read_frame(24'h000003, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFF00_FF00) begin errors++; $display("FAIL oor_high_array got=%h exp=ff00ff00", got); end
   endtask

   task automatic test_short_write();
      logic [31:0] got;
      logic [7:0]  last, mc;
      logic        bo, bc;
      int          w0;
      w0 = wr_pulses;
      write_frame(24'h000002, 32'h1234_0000, 2);
      checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("FAIL short_wr_done got=%0d exp=0", wr_pulses - w0); end
      read_frame(24'h000002, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL short_wr_array got=%h exp=ffffffff", got); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] got;
      logic [7:0]  d, b0, b1, b2, last, mc;
      logic        bo, bc;
      cs_low();
      xfer(8'h01, d); xfer(8'h00, d); xfer(8'h00, d);
      xfer(8'h03, b0);
      xfer(8'h00, b1);
      xfer(8'h00, b2);
      checks++; if ({b0, b1, b2} !== 24'hFF00FF) begin errors++; $display("FAIL mid_read_bytes got=%h exp=ff00ff", {b0, b1, b2}); end
      @(negedge p_clk);
      p_reset = 1'b1;
      @(negedge p_clk);
      checks++; if (s_miso !== 8'h00 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_state miso=%h busy=%b exp=00,0", s_miso, busy);
      end
      p_reset = 1'b0;
      s_css   = 1'b1;
      repeat (2) @(negedge p_clk);
      read_frame(24'h000003, got, last, bo, bc, mc);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_erased got=%h exp=ffffffff", got); end
      write_frame(24'h000005, 32'hDEAD_BEEF, 4);
      read_frame(24'h000005, got, last, bo, bc, mc);
      checks++; if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL post_reset_frame got=%h exp=deadbeef", got); end
   endtask

   initial begin
      test_reset();
      test_read_erased();
      test_write_read();
      test_bad_opcode();
      test_out_of_range();
      test_short_write();
      test_reset_mid_read();
      checks++; if (both_seen !== 0) begin errors++; $display("FAIL pulses_overlap got=%0d exp=0", both_seen); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
